// File: rtl/grid_overlay_ctrl.sv
// grid_overlay_ctrl: frame-synchronous, run-time configurable grid overlay.
// Geometry is written through a valid/ready port into pending registers and
// copied to the active set only at a frame boundary. Line positions are
// tracked with phase/division counters per axis.
// Optional build macro: GRID_DOTTED_EN (interior lines drawn dotted).

// One axis step: given the previous tracking state and the current
// coordinate's origin match, produce the tracking state for this position.
module grid_axis_step (
    input  logic       clear_i,
    input  logic       at_org_i,
    input  logic [7:0] pitch_i,
    input  logic [3:0] ndiv_i,
    input  logic [7:0] phase_i,
    input  logic [3:0] div_i,
    input  logic       in_i,
    output logic [7:0] phase_o,
    output logic [3:0] div_o,
    output logic       in_o
);
    logic [7:0] ph_base;
    logic [7:0] ph_inc;
    logic [3:0] dv_base;
    logic       in_base;

    assign ph_base = clear_i ? 8'd0 : phase_i;
    assign dv_base = clear_i ? 4'd0 : div_i;
    assign in_base = clear_i ? 1'b0 : in_i;
    assign ph_inc  = ph_base + 8'd1;

    // Restart at the origin; otherwise advance phase, wrap into the next
    // division, and leave the span once the last division line is passed.
    always_comb begin
        phase_o = ph_base;
        div_o   = dv_base;
        in_o    = in_base;
        if (at_org_i) begin
            phase_o = 8'd0;
            div_o   = 4'd0;
            in_o    = 1'b1;
        end else if (in_base) begin
            if (dv_base == ndiv_i) begin
                in_o = 1'b0;
            end else if (ph_inc == pitch_i) begin
                phase_o = 8'd0;
                div_o   = dv_base + 4'd1;
            end else begin
                phase_o = ph_inc;
            end
        end
    end
endmodule

module grid_overlay_ctrl #(
    parameter int DEF_X0    = 20,
    parameter int DEF_Y0    = 20,
    parameter int DEF_PITCH = 75,
    parameter int DEF_NCOLS = 10,
    parameter int DEF_NROWS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en_i,
    input  logic [10:0] x_i,
    input  logic [9:0]  y_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [10:0] cfg_x0_i,
    input  logic [9:0]  cfg_y0_i,
    input  logic [7:0]  cfg_pitch_i,
    input  logic [3:0]  cfg_ncols_i,
    input  logic [3:0]  cfg_nrows_i,
    output logic        cfg_applied_o,
    output logic        grid_on_o
);
    typedef struct packed {
        logic [10:0] x0;
        logic [9:0]  y0;
        logic [7:0]  pitch;
        logic [3:0]  ncols;
        logic [3:0]  nrows;
    } geo_t;

    typedef enum logic [1:0] {S_IDLE, S_PENDING, S_APPLY} state_t;

    localparam geo_t GEO_DEF = '{x0: 11'(DEF_X0), y0: 10'(DEF_Y0),
                                 pitch: 8'(DEF_PITCH), ncols: 4'(DEF_NCOLS),
                                 nrows: 4'(DEF_NROWS)};

    state_t state_q, state_d;
    geo_t   pend_q, pend_d, act_q, act_d, cfg_geo, geo;
    logic   capture, apply, fs, ls;

    logic [7:0] col_ph_q, col_ph_n, row_ph_q, row_ph_n, row_ph_cur;
    logic [3:0] col_dv_q, col_dv_n, row_dv_q, row_dv_n;
    logic       col_in_q, col_in_n, row_in_q, row_in_n, row_in_cur;
    logic       vline, hline, grid_d, grid_q;

    assign fs = pix_en_i && (x_i == 11'd0) && (y_i == 10'd0);
    assign ls = pix_en_i && (x_i == 11'd0);

    // Pitches below 2 would put a line on every pixel; hold them at 2.
    assign cfg_geo = '{x0: cfg_x0_i, y0: cfg_y0_i,
                       pitch: (cfg_pitch_i < 8'd2) ? 8'd2 : cfg_pitch_i,
                       ncols: cfg_ncols_i, nrows: cfg_nrows_i};

    // The FS pixel still sees the old set; during APPLY the pending set is
    // already the one in force so the pixel after FS uses new geometry.
    assign geo    = (state_q == S_APPLY) ? pend_q : act_q;
    assign pend_d = capture ? cfg_geo : pend_q;
    assign act_d  = apply ? pend_q : act_q;

    // Config FSM: accept one request in IDLE, wait for FS, then apply.
    always_comb begin
        state_d       = state_q;
        cfg_ready_o   = 1'b0;
        cfg_applied_o = 1'b0;
        capture       = 1'b0;
        apply         = 1'b0;
        case (state_q)
            S_IDLE: begin
                cfg_ready_o = 1'b1;
                if (cfg_valid_i) begin
                    capture = 1'b1;
                    state_d = S_PENDING;
                end
            end
            S_PENDING: if (fs) state_d = S_APPLY;
            S_APPLY: begin
                cfg_applied_o = 1'b1;
                apply         = 1'b1;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state and geometry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pend_q  <= GEO_DEF;
            act_q   <= GEO_DEF;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            act_q   <= act_d;
        end
    end

    // Horizontal tracking restarts at every line start.
    grid_axis_step u_col (
        .clear_i (ls),          .at_org_i (x_i == geo.x0),
        .pitch_i (geo.pitch),   .ndiv_i   (geo.ncols),
        .phase_i (col_ph_q),    .div_i    (col_dv_q),  .in_i (col_in_q),
        .phase_o (col_ph_n),    .div_o    (col_dv_n),  .in_o (col_in_n)
    );

    // Vertical tracking steps once per line and restarts at frame start.
    grid_axis_step u_row (
        .clear_i (fs),          .at_org_i (y_i == geo.y0),
        .pitch_i (geo.pitch),   .ndiv_i   (geo.nrows),
        .phase_i (row_ph_q),    .div_i    (row_dv_q),  .in_i (row_in_q),
        .phase_o (row_ph_n),    .div_o    (row_dv_n),  .in_o (row_in_n)
    );

    // The line-start pixel already belongs to the new line.
    assign row_ph_cur = ls ? row_ph_n : row_ph_q;
    assign row_in_cur = ls ? row_in_n : row_in_q;

`ifdef GRID_DOTTED_EN
    logic [3:0] row_dv_cur;
    logic       col_int, row_int;
    assign row_dv_cur = ls ? row_dv_n : row_dv_q;
    assign col_int    = (col_dv_n != 4'd0) && (col_dv_n < geo.ncols);
    assign row_int    = (row_dv_cur != 4'd0) && (row_dv_cur < geo.nrows);
    assign vline      = (col_ph_n == 8'd0) && !(col_int && y_i[0]);
    assign hline      = (row_ph_cur == 8'd0) && !(row_int && x_i[0]);
`else
    assign vline = (col_ph_n == 8'd0);
    assign hline = (row_ph_cur == 8'd0);
`endif

    assign grid_d = col_in_n && row_in_cur && (vline || hline);

    // Pixel-rate tracking state and the registered grid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_ph_q <= 8'd0;
            col_dv_q <= 4'd0;
            col_in_q <= 1'b0;
            row_ph_q <= 8'd0;
            row_dv_q <= 4'd0;
            row_in_q <= 1'b0;
            grid_q   <= 1'b0;
        end else if (pix_en_i) begin
            col_ph_q <= col_ph_n;
            col_dv_q <= col_dv_n;
            col_in_q <= col_in_n;
            grid_q   <= grid_d;
            if (ls) begin
                row_ph_q <= row_ph_n;
                row_dv_q <= row_dv_n;
                row_in_q <= row_in_n;
            end
        end
    end

    assign grid_on_o = grid_q;
endmodule
